// File: rtl/pixel_write_queue.sv
// Clips generator pixels to the frame, queues them, and strobes them to the VGA write port.
// Also runs the clear-screen sweep after draining the queue.
module pixel_write_queue #(
    parameter int          H_RES     = 160,
    parameter int          V_RES     = 120,
    parameter int          DEPTH     = 8,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [8:0] in_x_i,
    input  logic [8:0] in_y_i,
    input  logic [2:0] in_colour_i,
    input  logic       clear_req_i,
    input  logic       out_stall_i,
    output logic       plot_o,
    output logic [7:0] x_out_o,
    output logic [6:0] y_out_o,
    output logic [2:0] colour_out_o,
    output logic       busy_o,
    output logic       clear_done_o,
    output logic [7:0] drop_count_o
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef enum logic [1:0] {PASS, DRAIN, CLEAR} state_t;

    state_t        state_q;
    logic          clear_pending_q, done_arm_q, clear_done_q, plot_q;
    logic [7:0]    cx_q, x_q, drop_count_q;
    logic [6:0]    cy_q, y_q;
    logic [2:0]    colour_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    pix_t          mem_q [DEPTH];

    logic fifo_full, fifo_empty, xfer, in_range, push, drop, pop, cx_last, cy_last;
    pix_t head, wr_pix;

    always_comb begin
        fifo_full  = (count_q == (AW+1)'(DEPTH));
        fifo_empty = (count_q == '0);
        in_ready_o = (state_q == PASS) && !fifo_full && !clear_pending_q;
        xfer       = in_valid_i && in_ready_o;
        // Negative coordinates have bit 8 set; the rest compare as unsigned.
        in_range   = !in_x_i[8] && !in_y_i[8]
                     && ({1'b0, in_x_i[7:0]} < 9'(H_RES))
                     && (in_y_i[7:0] < 8'(V_RES));
        push       = xfer && in_range;
        drop       = xfer && !in_range;
        pop        = !fifo_empty && !out_stall_i && (state_q != CLEAR);
        head       = mem_q[rd_ptr_q];
        wr_pix     = '{x: in_x_i[7:0], y: in_y_i[6:0], c: in_colour_i};
        cx_last    = (cx_q == 8'(H_RES - 1));
        cy_last    = (cy_q == 7'(V_RES - 1));
        count_d    = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_pix;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= PASS;
            clear_pending_q <= 1'b0;
            done_arm_q      <= 1'b0;
            clear_done_q    <= 1'b0;
            plot_q          <= 1'b0;
            cx_q            <= '0;
            cy_q            <= '0;
            x_q             <= '0;
            y_q             <= '0;
            colour_q        <= '0;
            drop_count_q    <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            count_q      <= count_d;
            plot_q       <= 1'b0;
            clear_done_q <= 1'b0;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                plot_q   <= 1'b1;
                x_q      <= head.x;
                y_q      <= head.y;
                colour_q <= head.c;
            end
            if (drop && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 1'b1;

            case (state_q)
                PASS: begin
                    if (clear_pending_q)  state_q <= DRAIN;
                    else if (clear_req_i) clear_pending_q <= 1'b1;
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= CLEAR;
                        cx_q    <= '0;
                        cy_q    <= '0;
                    end
                end
                CLEAR: begin
                    // The cycle after the last sweep pixel finishes the clear.
                    if (done_arm_q) begin
                        done_arm_q      <= 1'b0;
                        clear_done_q    <= 1'b1;
                        clear_pending_q <= 1'b0;
                        state_q         <= PASS;
                    end else if (!out_stall_i) begin
                        plot_q   <= 1'b1;
                        x_q      <= cx_q;
                        y_q      <= cy_q;
                        colour_q <= BG_COLOUR;
                        if (cx_last) begin
                            cx_q <= '0;
                            cy_q <= cy_q + 1'b1;
                            if (cy_last) done_arm_q <= 1'b1;
                        end else begin
                            cx_q <= cx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= PASS;
            endcase
        end
    end

    assign plot_o       = plot_q;
    assign x_out_o      = x_q;
    assign y_out_o      = y_q;
    assign colour_out_o = colour_q;
    assign clear_done_o = clear_done_q;
    assign drop_count_o = drop_count_q;
    assign busy_o       = !fifo_empty || plot_q || clear_pending_q || (state_q != PASS);
endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed bench for pixel_write_queue: clipping, stall/fill, clear sweep, reset, saturation.
module tb_pixel_write_queue;
    logic       clk = 1'b0, rst = 1'b1;
    logic       in_valid = 1'b0, in_ready, clear_req = 1'b0, out_stall = 1'b0;
    logic [8:0] in_x = '0, in_y = '0;
    logic [2:0] in_colour = '0;
    logic       plot, busy, clear_done;
    logic [7:0] x_out, drop_count;
    logic [6:0] y_out;
    logic [2:0] colour_out;

    int compared = 0, mism = 0, cyc = 0;
    int qx[$], qy[$], qc[$], qt[$];

    pixel_write_queue dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_x_i(in_x), .in_y_i(in_y), .in_colour_i(in_colour),
        .clear_req_i(clear_req), .out_stall_i(out_stall),
        .plot_o(plot), .x_out_o(x_out), .y_out_o(y_out), .colour_out_o(colour_out),
        .busy_o(busy), .clear_done_o(clear_done), .drop_count_o(drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (plot) begin
            qx.push_back(int'(x_out));
            qy.push_back(int'(y_out));
            qc.push_back(int'(colour_out));
            qt.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        compared++;
        assert (got === exp) else begin
            mism++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int x, input int y, input int c);
        in_valid  = v;
        in_x      = 9'(x);
        in_y      = 9'(y);
        in_colour = 3'(c);
    endtask

    task automatic clrq();
        qx.delete(); qy.delete(); qc.delete(); qt.delete();
    endtask

    initial begin
        int sent, bad, seen, pulses, k;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_plot", plot, 0);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_ready", in_ready, 1);
        rst = 1'b0;

        // Single pixel latency
        @(negedge clk); drive(1, 10, 20, 5);
        @(negedge clk); drive(0, 0, 0, 0);
        chk("lat_plot_e0", plot, 0);
        @(negedge clk);
        chk("lat_plot_e1", plot, 1);
        chk("lat_x", x_out, 10);
        chk("lat_y", y_out, 20);
        chk("lat_c", colour_out, 5);
        @(negedge clk);
        chk("lat_busy_low", busy, 0);
        clrq();

        // Clipping
        drive(1, -3, 5, 1);
        @(negedge clk); drive(1, 160, 5, 2);
        @(negedge clk); drive(1, 5, 120, 3);
        @(negedge clk); drive(1, 159, 119, 6);
        @(negedge clk); drive(0, 0, 0, 0);
        repeat (4) @(negedge clk);
        chk("clip_drops", drop_count, 3);
        chk("clip_nplots", qx.size(), 1);
        if (qx.size() == 1) begin
            chk("clip_x", qx[0], 159);
            chk("clip_y", qy[0], 119);
            chk("clip_c", qc[0], 6);
        end
        clrq();

        // Stall, fill to full, then release
        out_stall = 1'b1;
        sent = 0;
        for (int i = 0; i < 12; i++) begin
            if (in_ready && sent < 9) begin
                drive(1, sent + 30, sent + 40, sent % 8);
                sent++;
            end else drive(0, 0, 0, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        chk("fill_sent", sent, 8);
        chk("fill_ready_low", in_ready, 0);
        chk("fill_no_plot", qx.size(), 0);
        out_stall = 1'b0;
        repeat (12) @(negedge clk);
        chk("drain_nplots", qx.size(), 8);
        bad = 0;
        for (int i = 0; i < qx.size(); i++) begin
            if (qx[i] != i + 30 || qy[i] != i + 40 || qc[i] != i % 8) bad++;
            if (i > 0 && qt[i] != qt[i-1] + 1) bad++;
        end
        chk("drain_order_consec", bad, 0);
        clrq();

        // Clear with buffered pixels and a coincident push
        out_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 100 + i, 50 + i, i + 1);
            @(negedge clk);
        end
        chk("clr_ready_before", in_ready, 1);
        drive(1, 104, 54, 5);
        clear_req = 1'b1;
        @(negedge clk);
        drive(0, 0, 0, 0);
        clear_req = 1'b0;
        out_stall = 1'b0;
        chk("clr_ready_low", in_ready, 0);
        chk("clr_busy", busy, 1);
        seen = 0; pulses = 0;
        for (int i = 0; i < 20000 && seen == 0; i++) begin
            clear_req = (i == 1000);
            @(negedge clk);
            if (clear_done) begin
                seen = 1; pulses++;
                chk("clr_ready_after", in_ready, 1);
            end
        end
        clear_req = 1'b0;
        chk("clr_done_seen", seen, 1);
        repeat (6) begin
            @(negedge clk);
            if (clear_done) pulses++;
        end
        chk("clr_done_pulses", pulses, 1);
        chk("clr_idle_after", busy, 0);
        chk("clr_nplots", qx.size(), 5 + 19200);
        bad = 0;
        for (int i = 0; i < 5 && i < qx.size(); i++)
            if (qx[i] != 100 + i || qy[i] != 50 + i || qc[i] != i + 1) bad++;
        chk("clr_buffered_first", bad, 0);
        bad = 0;
        for (int i = 0; i < 19200 && i + 5 < qx.size(); i++)
            if (qx[i+5] != i % 160 || qy[i+5] != i / 160 || qc[i+5] != 0) bad++;
        chk("clr_raster", bad, 0);
        clrq();

        // Reset mid-sweep
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 2000 && seen == 0; i++) begin
            @(negedge clk);
            if (plot && x_out == 49 && y_out == 3) seen = 1;
        end
        chk("mid_reached", seen, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_plot", plot, 0);
        @(negedge clk);
        chk("mid_rst_x", x_out, 0);
        chk("mid_rst_y", y_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        rst = 1'b0;
        clrq();
        @(negedge clk); drive(1, 7, 8, 3);
        @(negedge clk); drive(0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_plot", plot, 1);
        chk("post_rst_x", x_out, 7);
        chk("post_rst_y", y_out, 8);
        @(negedge clk);

        // Drop counter saturation
        drive(1, -1, 200, 0);
        for (k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 100) chk("sat_100", drop_count, 100);
            if (k == 255) chk("sat_255", drop_count, 255);
        end
        drive(0, 0, 0, 0);
        chk("sat_300", drop_count, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
